// File: rtl/serial_peak_pkg.sv
// rtl/serial_peak_pkg.sv - shared types and constants for the serial peak capture block
// Purpose: framing FSM state encoding, sample width and the signed sample type.
package serial_peak_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // PARITY is only entered when SERIAL_PARITY_EN is defined.
  typedef enum logic [1:0] {
    HUNT,
    SHIFT,
    PARITY
  } state_t;

endpackage

// File: rtl/abs_mag8.sv
// rtl/abs_mag8.sv - combinational two's-complement to unsigned magnitude
// Purpose: |value| as an 8-bit unsigned number; -128 maps to 128, which still fits.
// Ports:
//   value  in   sample_t  signed sample
//   mag    out  8         unsigned magnitude
module abs_mag8
  import serial_peak_pkg::*;
(
  input  sample_t               value,
  output logic [SAMPLE_W-1:0]   mag
);

  logic [SAMPLE_W-1:0] raw;

  always_comb begin
    raw = value;
    mag = raw[SAMPLE_W-1] ? (~raw + {{(SAMPLE_W-1){1'b0}}, 1'b1}) : raw;
  end

endmodule

// File: rtl/serial_peak_capture.sv
// rtl/serial_peak_capture.sv - serial sample deserialiser with windowed peak-magnitude capture
// Purpose: deserialise MSB-first signed bytes, keep the largest-|value| sample of each
//   WINDOW_LEN-sample window and publish it as a held byte with a one-cycle strobe.
// Optional feature: define SERIAL_PARITY_EN for a trailing even-parity bit per sample.
// Ports:
//   clk         in   1  clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   s_sync      in   1  frame alignment; current s_data bit is sample bit 7
//   s_valid     in   1  qualifies s_data
//   s_data      in   1  serial data, MSB first
//   peak_out    out  8  peak sample of the last completed window, held
//   peak_valid  out  1  one-cycle pulse when peak_out updates
//   parity_err  out  1  sticky parity error (0 without SERIAL_PARITY_EN)
module serial_peak_capture
  import serial_peak_pkg::*;
#(
  parameter int WINDOW_LEN = 16,
  localparam int CNT_W = $clog2(WINDOW_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_sync,
  input  logic                s_valid,
  input  logic                s_data,
  output logic [SAMPLE_W-1:0] peak_out,
  output logic                peak_valid,
  output logic                parity_err
);

  // With parity the 8th data bit is shifted in and the byte waits in shift_reg for the
  // parity bit; without it the 8th bit is merged straight into the captured byte.
`ifdef SERIAL_PARITY_EN
  localparam int SR_W = SAMPLE_W;
`else
  localparam int SR_W = SAMPLE_W - 1;
`endif

  state_t              state_q, state_d;
  logic [SR_W-1:0]     shift_reg;
  logic [2:0]          bit_cnt;
  sample_t             sample_q;
  logic                pend;
  sample_t             peak_reg;
  logic [CNT_W-1:0]    win_cnt;
  sample_t             win_q;
  logic                pub;

  logic                start_bit;
  logic                shift_bit;
  logic                capture;
  sample_t             cap_byte;
  logic [SAMPLE_W-1:0] mag_sample;
  logic [SAMPLE_W-1:0] mag_peak;
  sample_t             winner;
`ifdef SERIAL_PARITY_EN
  logic                par_fail;
`endif

  abs_mag8 u_abs_sample (.value(sample_q), .mag(mag_sample));
  abs_mag8 u_abs_peak   (.value(peak_reg), .mag(mag_peak));

  // Strict compare: on a magnitude tie the earlier sample stays.
  assign winner = (mag_sample > mag_peak) ? sample_q : peak_reg;

`ifdef SERIAL_PARITY_EN
  assign cap_byte = shift_reg;
`else
  assign cap_byte = {shift_reg, s_data};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_bit = 1'b0;
    shift_bit = 1'b0;
    capture   = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_fail  = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        if (s_valid && s_sync) begin
          start_bit = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (s_valid) begin
          if (s_sync) begin
            start_bit = 1'b1;
          end else if (bit_cnt == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            shift_bit = 1'b1;
            state_d   = PARITY;
`else
            capture   = 1'b1;
`endif
          end else begin
            shift_bit = 1'b1;
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        if (s_valid) begin
          if (s_sync) begin
            start_bit = 1'b1;
            state_d   = SHIFT;
          end else if (s_data == ^shift_reg) begin
            capture   = 1'b1;
            state_d   = SHIFT;
          end else begin
            par_fail  = 1'b1;
            state_d   = HUNT;
          end
        end
      end
`endif
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= 3'd0;
      sample_q   <= '0;
      pend       <= 1'b0;
      peak_reg   <= '0;
      win_cnt    <= '0;
      win_q      <= '0;
      pub        <= 1'b0;
      peak_out   <= '0;
      peak_valid <= 1'b0;
    end else begin
      if (start_bit) begin
        shift_reg <= SR_W'(s_data);
        bit_cnt   <= 3'd1;
      end else if (shift_bit) begin
        shift_reg <= {shift_reg[SR_W-2:0], s_data};
        bit_cnt   <= bit_cnt + 3'd1;
      end else if (capture) begin
        bit_cnt   <= 3'd0;
      end

      pend <= capture;
      if (capture) sample_q <= cap_byte;

      // Update stage: fold the pending sample into the window; the last sample of a
      // window hands the winner to the publish stage and restarts the window.
      pub <= 1'b0;
      if (pend) begin
        if (win_cnt == CNT_W'(WINDOW_LEN - 1)) begin
          win_q    <= winner;
          pub      <= 1'b1;
          peak_reg <= '0;
          win_cnt  <= '0;
        end else begin
          peak_reg <= winner;
          win_cnt  <= win_cnt + CNT_W'(1);
        end
      end

      peak_valid <= pub;
      if (pub) peak_out <= win_q;
    end
  end

`ifdef SERIAL_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           parity_err <= 1'b0;
    else if (par_fail) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_peak_capture.sv
// tb/tb_serial_peak_capture.sv - directed self-checking bench for serial_peak_capture
module tb_serial_peak_capture;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_sync = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_data = 1'b0;
  logic [7:0] peak_out;
  logic       peak_valid;
  logic       parity_err;

  int         checks = 0;
  int         failures = 0;
  int         pulse_cnt = 0;
  logic [7:0] last_peak = 8'h00;

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0]      exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_peak_capture #(.WINDOW_LEN(WL)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_sync     (s_sync),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .peak_out   (peak_out),
    .peak_valid (peak_valid),
    .parity_err (parity_err)
  );

  always @(negedge clk) begin
    if (!rst && peak_valid) begin
      pulse_cnt = pulse_cnt + 1;
      last_peak = peak_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic sy, input logic d);
    s_sync  = sy;
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_sync  = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sy);
    for (int i = 7; i >= 0; i--) send_bit(sy && (i == 7), b[i]);
`ifdef SERIAL_PARITY_EN
    send_bit(1'b0, ^b);
`endif
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b, input logic sy);
    for (int i = 7; i >= 0; i--) send_bit(sy && (i == 7), b[i]);
    send_bit(1'b0, ~(^b));
  endtask
`endif

  task automatic set_vec(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
    vecs[idx].s[0] = a;
    vecs[idx].s[1] = b;
    vecs[idx].s[2] = c;
    vecs[idx].s[3] = d;
    vecs[idx].exp  = e;
  endtask

  initial begin
    int p0;

    set_vec(0, 8'h05, 8'hEC, 8'h07, 8'h03, 8'hEC);
    set_vec(1, 8'h80, 8'h7F, 8'h01, 8'h02, 8'h80);
    set_vec(2, 8'h09, 8'hF7, 8'h00, 8'h00, 8'h09);
    set_vec(3, 8'hF7, 8'h09, 8'h01, 8'h01, 8'hF7);
    set_vec(4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(5, 8'h01, 8'h02, 8'h03, 8'hFC, 8'hFC);
    set_vec(6, 8'h7F, 8'h81, 8'h7E, 8'h00, 8'h7F);
    set_vec(7, 8'hFF, 8'h80, 8'h80, 8'h05, 8'h80);

    tick();
    tick();
    check("reset_peak_out", peak_out, 8'h00);
    check("reset_peak_valid", peak_valid, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < WL; k++) send_byte(vecs[v].s[k], k == 0);
      tick();
      check($sformatf("vec%0d_valid_e1", v), peak_valid, 1'b0);
      tick();
      check($sformatf("vec%0d_valid_e2", v), peak_valid, 1'b1);
      check($sformatf("vec%0d_peak", v), peak_out, vecs[v].exp);
      tick();
      check($sformatf("vec%0d_valid_e3", v), peak_valid, 1'b0);
      check($sformatf("vec%0d_peak_held", v), peak_out, vecs[v].exp);
    end

    // Partial sample interrupted by a new sync.
    p0 = pulse_cnt;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_byte(8'h2A, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    tick();
    tick();
    check("resync_valid", peak_valid, 1'b1);
    check("resync_peak", peak_out, 8'h2A);
    tick();
    check("resync_pulses", pulse_cnt - p0, 1);

    // Asynchronous reset mid-window.
    send_byte(8'h64, 1'b1);
    send_byte(8'h9C, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_peak_out", peak_out, 8'h00);
    check("async_rst_peak_valid", peak_valid, 1'b0);
    check("async_rst_parity_err", parity_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    p0 = pulse_cnt;
    send_byte(8'h32, 1'b1);
    send_byte(8'h32, 1'b0);
    send_byte(8'h32, 1'b0);
    tick();
    tick();
    tick();
    check("rst_no_early_pulse", pulse_cnt - p0, 0);
    send_byte(8'h32, 1'b0);
    tick();
    tick();
    check("rst_window_valid", peak_valid, 1'b1);
    check("rst_window_peak", peak_out, 8'h32);
    tick();

    // Back-to-back samples, s_valid held high throughout.
    p0 = pulse_cnt;
    for (int k = 1; k <= 8; k++) send_byte(8'(k), k == 1);
    for (int k = 0; k < 4; k++) tick();
    check("b2b_pulses", pulse_cnt - p0, 2);
    check("b2b_last_peak", last_peak, 8'h08);

`ifdef SERIAL_PARITY_EN
    p0 = pulse_cnt;
    send_byte(8'h0A, 1'b1);
    send_bad_parity(8'h14, 1'b0);
    check("parity_err_set", parity_err, 1'b1);
    send_byte(8'h64, 1'b0);
    send_byte(8'h1E, 1'b1);
    send_byte(8'h28, 1'b0);
    send_byte(8'h05, 1'b0);
    tick();
    tick();
    check("parity_window_valid", peak_valid, 1'b1);
    check("parity_window_peak", peak_out, 8'h28);
    tick();
    check("parity_pulses", pulse_cnt - p0, 1);
    check("parity_err_sticky", parity_err, 1'b1);
`else
    check("parity_err_tied", parity_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
